// File: rtl/arcade_input_ctrl.sv
// Player-input conditioning: PS/2 key decode, joystick merge with optional
// 90-degree rotation, and a metered coin pulse with lockout.
module arcade_input_ctrl #(
    parameter int unsigned COIN_PULSE = 1200000,
    parameter int unsigned COIN_LOCK  = 2400000,
    parameter int unsigned CW         = 22
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    output logic        up1,
    output logic        down1,
    output logic        left1,
    output logic        right1,
    output logic        fire1,
    output logic        up2,
    output logic        down2,
    output logic        left2,
    output logic        right2,
    output logic        fire2,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin_busy
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        LOCK
    } coin_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire;
        logic start1;
        logic start2;
        logic coin_a;
        logic coin_b;
        logic p2_up;
        logic p2_down;
        logic p2_left;
        logic p2_right;
        logic p2_fire;
    } keys_t;

    typedef struct packed {
        logic up1;
        logic down1;
        logic left1;
        logic right1;
        logic fire1;
        logic up2;
        logic down2;
        logic left2;
        logic right2;
        logic fire2;
        logic start1;
        logic start2;
    } ctrl_t;

    localparam logic [CW-1:0] PULSE_LOAD = CW'(COIN_PULSE - 1);
    localparam logic [CW-1:0] LOCK_LOAD  = CW'(COIN_LOCK - 1);

    logic        tog_q;
    logic        ref_valid_q;
    logic        key_event;
    logic        key_ext;
    logic        key_prs;
    logic [7:0]  key_code;
    keys_t       keys_q, keys_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        req, req_q, coin_trig;
    coin_state_e state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic        coin_q, coin_d;
    logic        unused_joy;

    assign unused_joy = ^joy[15:7];

    assign key_ext   = ps2_key[8];
    assign key_prs   = ps2_key[9];
    assign key_code  = ps2_key[7:0];
    // The first cycle after reset only captures the toggle reference.
    assign key_event = ref_valid_q && (tog_q != ps2_key[10]);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q       <= 1'b0;
            ref_valid_q <= 1'b0;
            keys_q      <= '0;
            ctrl_q      <= '0;
            req_q       <= 1'b0;
        end else begin
            tog_q       <= ps2_key[10];
            ref_valid_q <= 1'b1;
            keys_q      <= keys_d;
            ctrl_q      <= ctrl_d;
            req_q       <= req;
        end
    end

    always_comb begin
        keys_d = keys_q;
        if (key_event) begin
            case (key_code)
                8'h75:   keys_d.up    = key_prs;
                8'h72:   keys_d.down  = key_prs;
                8'h6B:   keys_d.left  = key_prs;
                8'h74:   keys_d.right = key_prs;
                default: begin
                    if (!key_ext) begin
                        case (key_code)
                            8'h29, 8'h14: keys_d.fire     = key_prs;
                            8'h05, 8'h16: keys_d.start1   = key_prs;
                            8'h06, 8'h1E: keys_d.start2   = key_prs;
                            8'h2E:        keys_d.coin_a   = key_prs;
                            8'h36:        keys_d.coin_b   = key_prs;
                            8'h2D:        keys_d.p2_up    = key_prs;
                            8'h2B:        keys_d.p2_down  = key_prs;
                            8'h23:        keys_d.p2_left  = key_prs;
                            8'h34:        keys_d.p2_right = key_prs;
                            8'h1C:        keys_d.p2_fire  = key_prs;
                            default:      ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        logic u1, d1, l1, r1, u2, d2, l2, r2;
        u1 = keys_q.up       | joy[3];
        d1 = keys_q.down     | joy[2];
        l1 = keys_q.left     | joy[1];
        r1 = keys_q.right    | joy[0];
        u2 = keys_q.p2_up    | joy[3];
        d2 = keys_q.p2_down  | joy[2];
        l2 = keys_q.p2_left  | joy[1];
        r2 = keys_q.p2_right | joy[0];
        ctrl_d        = '0;
        ctrl_d.up1    = rotate ? l1 : u1;
        ctrl_d.down1  = rotate ? r1 : d1;
        ctrl_d.left1  = rotate ? d1 : l1;
        ctrl_d.right1 = rotate ? u1 : r1;
        ctrl_d.up2    = rotate ? l2 : u2;
        ctrl_d.down2  = rotate ? r2 : d2;
        ctrl_d.left2  = rotate ? d2 : l2;
        ctrl_d.right2 = rotate ? u2 : r2;
        ctrl_d.fire1  = keys_q.fire    | joy[4];
        ctrl_d.fire2  = keys_q.p2_fire | joy[4];
        ctrl_d.start1 = keys_q.start1  | joy[5];
        ctrl_d.start2 = keys_q.start2  | joy[6];
    end

    // req_q tracks continuously, so a req held through LOCK never retriggers.
    assign req       = keys_q.coin_a | keys_q.coin_b | joy[5] | joy[6];
    assign coin_trig = req & ~req_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            coin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            coin_q  <= coin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        coin_d  = coin_q;
        case (state_q)
            IDLE: begin
                if (coin_trig) begin
                    state_d = PULSE;
                    timer_d = PULSE_LOAD;
                    coin_d  = 1'b1;
                end
            end
            PULSE: begin
                if (timer_q == '0) begin
                    state_d = LOCK;
                    timer_d = LOCK_LOAD;
                    coin_d  = 1'b0;
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end
            LOCK: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                coin_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        coin_busy = (state_q != IDLE);
    end

    assign coin1  = coin_q;
    assign up1    = ctrl_q.up1;
    assign down1  = ctrl_q.down1;
    assign left1  = ctrl_q.left1;
    assign right1 = ctrl_q.right1;
    assign fire1  = ctrl_q.fire1;
    assign up2    = ctrl_q.up2;
    assign down2  = ctrl_q.down2;
    assign left2  = ctrl_q.left2;
    assign right2 = ctrl_q.right2;
    assign fire2  = ctrl_q.fire2;
    assign start1 = ctrl_q.start1;
    assign start2 = ctrl_q.start2;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed self-checking bench for arcade_input_ctrl with short coin timings.
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        rotate;
    logic        up1, down1, left1, right1, fire1;
    logic        up2, down2, left2, right2, fire2;
    logic        start1, start2, coin1, coin_busy;
    logic [13:0] outs;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          rises, high, busy, first_rise;

    arcade_input_ctrl #(
        .COIN_PULSE (4),
        .COIN_LOCK  (6),
        .CW         (4)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .joy       (joy),
        .rotate    (rotate),
        .up1       (up1),
        .down1     (down1),
        .left1     (left1),
        .right1    (right1),
        .fire1     (fire1),
        .up2       (up2),
        .down2     (down2),
        .left2     (left2),
        .right2    (right2),
        .fire2     (fire2),
        .start1    (start1),
        .start2    (start2),
        .coin1     (coin1),
        .coin_busy (coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    assign outs = {up1, down1, left1, right1, fire1, up2, down2, left2, right2,
                   fire2, start1, start2, coin1, coin_busy};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic key(input logic prs, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], prs, ext, code};
    endtask

    task automatic run(input int n);
        logic prev;
        rises      = 0;
        high       = 0;
        busy       = 0;
        first_rise = -1;
        prev       = coin1;
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (coin1 && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            if (coin1) high++;
            if (coin_busy) busy++;
            prev = coin1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        ps2_key = '0;
        joy     = '0;
        rotate  = 1'b0;
        step(2);
        check("reset_outs", 32'(outs), 32'h0);
        reset = 1'b0;
        step(1);

        // Key decode and 2-cycle latency
        key(1'b1, 1'b0, 8'h75); step(1); check("up1_lat1", 32'(up1), 32'h0);
        step(1);                         check("up1_press", 32'(up1), 32'h1);
        key(1'b0, 1'b0, 8'h75); step(2); check("up1_release", 32'(up1), 32'h0);
        key(1'b1, 1'b1, 8'h75); step(2); check("up1_ext", 32'(up1), 32'h1);
        key(1'b0, 1'b1, 8'h75); step(2); check("up1_ext_rel", 32'(up1), 32'h0);
        key(1'b1, 1'b1, 8'h29); step(2); check("fire1_ext_ignored", 32'(fire1), 32'h0);
        key(1'b1, 1'b0, 8'h29); step(2); check("fire1_press", 32'(fire1), 32'h1);
        key(1'b0, 1'b0, 8'h29); step(2);
        key(1'b1, 1'b0, 8'h2D); step(2); check("up2_press", 32'(up2), 32'h1);
        key(1'b0, 1'b0, 8'h2D); step(2);
        key(1'b1, 1'b0, 8'h1E); step(2); check("start2_press", 32'(start2), 32'h1);
        key(1'b0, 1'b0, 8'h1E); step(2); check("start2_release", 32'(start2), 32'h0);

        // Rotation with joystick, 1-cycle latency
        rotate = 1'b1; joy = 16'h0008; step(1);
        check("rot_right1", 32'(right1), 32'h1);
        check("rot_up1", 32'(up1), 32'h0);
        check("rot_right2", 32'(right2), 32'h1);
        rotate = 1'b0; step(1);
        check("norot_up1", 32'(up1), 32'h1);
        check("norot_right1", 32'(right1), 32'h0);
        joy = '0; step(1);
        check("idle_outs", 32'(outs), 32'h0);

        // Held coin key: one pulse of 4, busy for 10
        key(1'b1, 1'b0, 8'h2E); run(20);
        check("coin_first_rise", 32'(first_rise), 32'd2);
        check("coin_rises_held", 32'(rises), 32'd1);
        check("coin_high", 32'(high), 32'd4);
        check("coin_busy_len", 32'(busy), 32'd10);
        key(1'b0, 1'b0, 8'h2E); step(2);

        // Re-press during LOCK is ignored
        key(1'b1, 1'b0, 8'h2E); run(7);
        check("lock_rises", 32'(rises), 32'd1);
        check("lock_busy", 32'(coin_busy), 32'h1);
        check("lock_coin1", 32'(coin1), 32'h0);
        key(1'b0, 1'b0, 8'h2E); run(2);
        key(1'b1, 1'b0, 8'h2E); run(6);
        check("lock_repress", 32'(rises), 32'd0);
        check("lock_done_busy", 32'(coin_busy), 32'h0);
        run(4);
        check("held_no_retrigger", 32'(rises), 32'd0);
        key(1'b0, 1'b0, 8'h2E); run(3);
        key(1'b1, 1'b0, 8'h2E); run(8);
        check("repress_rises", 32'(rises), 32'd1);
        check("repress_high", 32'(high), 32'd4);
        key(1'b0, 1'b0, 8'h2E); run(12);

        // joy[5] and coinB key rising together: one pulse
        key(1'b1, 1'b0, 8'h36); step(1);
        joy = 16'h0020; run(12);
        check("dual_rises", 32'(rises), 32'd1);
        check("dual_first_rise", 32'(first_rise), 32'd1);
        check("dual_high", 32'(high), 32'd4);
        check("dual_start1", 32'(start1), 32'h1);
        joy = '0; key(1'b0, 1'b0, 8'h36); run(12);
        check("dual_rel_start1", 32'(start1), 32'h0);
        check("dual_rel_rises", 32'(rises), 32'd0);
        check("dual_rel_busy", 32'(coin_busy), 32'h0);

        // Reset mid-pulse, toggle left high across reset
        if (ps2_key[10]) begin
            key(1'b0, 1'b0, 8'h00); step(1);
        end
        key(1'b1, 1'b0, 8'h2E); joy = 16'h0010; run(3);
        check("pre_reset_coin1", 32'(coin1), 32'h1);
        check("pre_reset_fire1", 32'(fire1), 32'h1);
        reset = 1'b1; #1;
        check("reset_async_outs", 32'(outs), 32'h0);
        joy = '0; step(1);
        reset = 1'b0; run(3);
        check("post_reset_rises", 32'(rises), 32'd0);
        check("post_reset_outs", 32'(outs), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
